cr_file: RTL and testbench
==========================

# cr_file

Condition-register file for the fixed-point pipeline: holds the architectural 32-bit CR and accepts field-granular 4-bit results (lt/gt/eq/so) from the ALU record-form path and the compare unit. It supplies single CR bits to isel/branch consumers. A per-field pending scoreboard holds issue, reads and mtcrf until outstanding results have landed. Sits between execute writeback and the decode/issue stage, as the producer side of every CR bit that isel selects on.

## Interface
- No parameters; 8 fields × 4 bits fixed. Field i occupies cr[31-4i : 28-4i] (field 0 = MSB). Within a field, bit 3 = lt, 2 = gt, 1 = eq, 0 = so.
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- iss_valid  in  1  issuing instruction reserves a CR field
- iss_field  in  3  field to reserve
- iss_ready  out  1  reservation accepted this cycle
- wb0_valid / wb0_field / wb0_data  in  1/3/4  ALU writeback port
- wb1_valid / wb1_field / wb1_data  in  1/3/4  compare-unit writeback port
- mt_valid  in  1  mtcrf request
- mt_mask  in  8  bit i set = update field i (mask bit 7 = field 0)
- mt_data  in  32  new CR image
- mt_ready  out  1  mtcrf accepted this cycle
- rd_bc  in  5  CR bit index, 0 = cr[31]
- rd_bit  out  1  selected bit, bypassed
- rd_ready  out  1  rd_bit is valid this cycle
- cr  out  32  registered architectural CR
- busy  out  1  any field pending
- err  out  1  sticky protocol error

## Operation
- State: cr[31:0], pend[7:0], err. Reset (sync): cr = 0, pend = 0, err = 0; all outstanding reservations are dropped.
- Writeback: a wbX_valid targeting a pending field writes wbX_data into that field and clears pend for it at the next edge.
- Writeback to a non-pending field: ignored (cr unchanged) and sets err.
- Both wb ports valid on the same field: wb0 data is written, wb1 is dropped, err is set, pend is cleared.
- Issue: iss_ready = !pend[iss_field] OR a valid writeback targets iss_field this cycle. On iss_valid && iss_ready, pend[iss_field] is set at the next edge; set takes priority over a same-cycle clear.
  - iss_valid with !iss_ready: no state change; the requester holds.
- mtcrf: mt_ready = (mt_mask & pend) == 0, with pend bits cleared by same-cycle writebacks counted as not pending. On mt_valid && mt_ready, the masked fields load from mt_data at the next edge.
  - A same-cycle issue reserving a masked field is allowed: its pend is set and mt data is written.
- Read: field f = rd_bc[4:2].
  - rd_ready = !pend[f] OR a valid writeback hits f this cycle.
  - rd_bit is taken from writeback data when bypassing (wb0 before wb1), otherwise from cr.
  - rd_bit is don't-care when rd_ready = 0.
- busy = |pend. err clears only on reset.

## Timing
- Writeback to cr visible: 1 cycle (registered). Bypass to rd_bit: 0 cycles (combinational).
- iss_ready, mt_ready, rd_ready, rd_bit are combinational from inputs and state; no registered handshake.
- Back-to-back: a writeback and a new reservation of the same field in one cycle leaves pend = 1 and cr updated.
- All outputs except rd_bit/ready signals are registered; reset values: cr = 0, busy = 0, err = 0. With pend = 0 after reset: iss_ready = 1, mt_ready = 1, rd_ready = 1, rd_bit = 0.

## Test plan
- Reset then idle: cr = 0, busy = 0, rd_ready = 1 for all 32 rd_bc values, rd_bit = 0.
- Reserve field 2, then hold rd_bc = 9 → rd_ready = 0. Next cycle wb0 field 2 data 4'b0100 → same cycle rd_ready = 1, rd_bit = 1; next cycle cr[23:20] = 4'b0100, busy = 0.
- Field 5 pending; iss_valid field 5 plus wb1 field 5 data 4'b1000 in the same cycle → iss_ready = 1; next cycle cr[11:8] = 4'b1000, pend[5] = 1.
- mtcrf mask 8'h81, data 32'hA000_0005, while field 7 pending → mt_ready = 0. After wb0 clears field 7 → mt_ready = 1; cr[31:28] = 4'hA, cr[3:0] = 4'h5.
- wb0 and wb1 both hit pending field 0 with 4'h2 / 4'h4 → cr[31:28] = 4'h2, err = 1, held until reset. Also: wb to non-pending field 3 → cr unchanged, err = 1.
- Reset asserted with pend = 8'hFF mid-stream → next cycle pend = 0, cr = 0, err = 0.

Source files
------------

// File: rtl/cr_file.sv
// cr_file: condition-register file with per-field pending scoreboard.
// Holds the architectural 32-bit CR (field 0 = cr[31:28]). Accepts 4-bit
// field writebacks from the ALU (wb0) and compare unit (wb1), reserves
// fields at issue, loads masked fields on mtcrf and supplies single CR bits
// with same-cycle writeback bypass.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   iss_valid/iss_field/iss_ready    field reservation handshake
//   wb0_*/wb1_*                      field writeback ports (wb0 has priority)
//   mt_valid/mt_mask/mt_data/mt_ready mtcrf request (mask bit 7 = field 0)
//   rd_bc/rd_bit/rd_ready            CR bit read (rd_bc 0 = cr[31])
//   cr, busy, err                    registered CR, any-pending, sticky error
module cr_file (
  input  logic        clk,
  input  logic        reset,
  input  logic        iss_valid,
  input  logic [2:0]  iss_field,
  output logic        iss_ready,
  input  logic        wb0_valid,
  input  logic [2:0]  wb0_field,
  input  logic [3:0]  wb0_data,
  input  logic        wb1_valid,
  input  logic [2:0]  wb1_field,
  input  logic [3:0]  wb1_data,
  input  logic        mt_valid,
  input  logic [7:0]  mt_mask,
  input  logic [31:0] mt_data,
  output logic        mt_ready,
  input  logic [4:0]  rd_bc,
  output logic        rd_bit,
  output logic        rd_ready,
  output logic [31:0] cr,
  output logic        busy,
  output logic        err
);

  localparam int unsigned NFIELD = 8;
  localparam int unsigned FW     = 4;
  localparam int unsigned CRW    = NFIELD * FW;

  logic [CRW-1:0]    r_cr;
  logic [NFIELD-1:0] r_pend;
  logic              r_busy;
  logic              r_err;

  logic [NFIELD-1:0] w_hit0;     // wb0 targets field (index = field number)
  logic [NFIELD-1:0] w_hit1;
  logic [NFIELD-1:0] w_clr;      // pending fields retired this cycle
  logic [NFIELD-1:0] w_set;
  logic [NFIELD-1:0] w_mt_fld;   // mt_mask re-indexed by field number
  logic [NFIELD-1:0] w_pend_nxt;
  logic [CRW-1:0]    w_cr_nxt;
  logic              w_err_set;
  logic [2:0]        w_rd_f;
  logic [1:0]        w_rd_sel;

  // Decode writeback hits, clears, reservations and next CR image.
  always_comb begin
    w_hit0   = '0;
    w_hit1   = '0;
    w_mt_fld = '0;
    w_cr_nxt = r_cr;
    for (int f = 0; f < int'(NFIELD); f++) begin
      w_hit0[f]   = wb0_valid && (wb0_field == 3'(f));
      w_hit1[f]   = wb1_valid && (wb1_field == 3'(f));
      w_mt_fld[f] = mt_mask[NFIELD-1-f];
    end
    w_clr = (w_hit0 | w_hit1) & r_pend;

    iss_ready = !r_pend[iss_field] || w_hit0[iss_field] || w_hit1[iss_field];
    mt_ready  = ((w_mt_fld & r_pend & ~w_clr) == '0);
    w_set     = '0;
    if (iss_valid && iss_ready) w_set[iss_field] = 1'b1;
    w_pend_nxt = (r_pend & ~w_clr) | w_set;

    // mtcrf is younger than any retiring writeback, so it overrides it.
    for (int f = 0; f < int'(NFIELD); f++) begin
      if (w_clr[f]) begin
        if (w_hit0[f]) w_cr_nxt[(NFIELD-1-f)*FW +: FW] = wb0_data;
        else           w_cr_nxt[(NFIELD-1-f)*FW +: FW] = wb1_data;
      end
      if (mt_valid && mt_ready && w_mt_fld[f])
        w_cr_nxt[(NFIELD-1-f)*FW +: FW] = mt_data[(NFIELD-1-f)*FW +: FW];
    end

    w_err_set = ((w_hit0 | w_hit1) & ~r_pend) != '0
             || (wb0_valid && wb1_valid && (wb0_field == wb1_field));
  end

  // Bit read with bypass from a writeback that retires the read field.
  always_comb begin
    w_rd_f   = rd_bc[4:2];
    w_rd_sel = 2'(3 - int'(rd_bc[1:0]));
    rd_ready = !r_pend[w_rd_f] || w_clr[w_rd_f];
    if (w_clr[w_rd_f] && w_hit0[w_rd_f])
      rd_bit = wb0_data[w_rd_sel];
    else if (w_clr[w_rd_f])
      rd_bit = wb1_data[w_rd_sel];
    else
      rd_bit = r_cr[5'(31 - int'(rd_bc))];
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cr   <= '0;
      r_pend <= '0;
      r_busy <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_cr   <= w_cr_nxt;
      r_pend <= w_pend_nxt;
      r_busy <= |w_pend_nxt;
      r_err  <= r_err | w_err_set;
    end
  end

  assign cr   = r_cr;
  assign busy = r_busy;
  assign err  = r_err;

endmodule

// File: tb/tb_cr_file.sv
// Directed self-checking bench for cr_file.
module tb_cr_file;

  logic        clk = 1'b0;
  logic        reset;
  logic        iss_valid;
  logic [2:0]  iss_field;
  logic        iss_ready;
  logic        wb0_valid;
  logic [2:0]  wb0_field;
  logic [3:0]  wb0_data;
  logic        wb1_valid;
  logic [2:0]  wb1_field;
  logic [3:0]  wb1_data;
  logic        mt_valid;
  logic [7:0]  mt_mask;
  logic [31:0] mt_data;
  logic        mt_ready;
  logic [4:0]  rd_bc;
  logic        rd_bit;
  logic        rd_ready;
  logic [31:0] cr;
  logic        busy;
  logic        err;

  int n_chk  = 0;
  int n_pass = 0;

  cr_file dut (
    .clk(clk), .reset(reset),
    .iss_valid(iss_valid), .iss_field(iss_field), .iss_ready(iss_ready),
    .wb0_valid(wb0_valid), .wb0_field(wb0_field), .wb0_data(wb0_data),
    .wb1_valid(wb1_valid), .wb1_field(wb1_field), .wb1_data(wb1_data),
    .mt_valid(mt_valid), .mt_mask(mt_mask), .mt_data(mt_data), .mt_ready(mt_ready),
    .rd_bc(rd_bc), .rd_bit(rd_bit), .rd_ready(rd_ready),
    .cr(cr), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    iss_valid = 1'b0; iss_field = '0;
    wb0_valid = 1'b0; wb0_field = '0; wb0_data = '0;
    wb1_valid = 1'b0; wb1_field = '0; wb1_data = '0;
    mt_valid  = 1'b0; mt_mask   = '0; mt_data  = '0;
    rd_bc     = '0;
  endtask

  task automatic issue(input logic [2:0] f);
    iss_valid = 1'b1; iss_field = f;
    tick();
    iss_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    idle_in();
    do_reset();

    // Idle after reset: everything readable, all zero.
    chk("rst_cr", cr, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_iss_ready", 32'(iss_ready), 32'h1);
    chk("rst_mt_ready", 32'(mt_ready), 32'h1);
    for (int b = 0; b < 32; b++) begin
      rd_bc = 5'(b);
      #1;
      chk("rst_rd_ready", 32'(rd_ready), 32'h1);
      chk("rst_rd_bit", 32'(rd_bit), 32'h0);
    end

    // Reserve field 2, read bit 9 blocked, then bypassed from wb0.
    issue(3'd2);
    chk("f2_busy", 32'(busy), 32'h1);
    rd_bc = 5'd9;
    #1;
    chk("f2_rd_blocked", 32'(rd_ready), 32'h0);
    wb0_valid = 1'b1; wb0_field = 3'd2; wb0_data = 4'b0100;
    #1;
    chk("f2_rd_bypass_ready", 32'(rd_ready), 32'h1);
    chk("f2_rd_bypass_bit", 32'(rd_bit), 32'h1);
    tick();
    wb0_valid = 1'b0;
    #1;
    chk("f2_cr", cr, 32'h0040_0000);
    chk("f2_busy_clr", 32'(busy), 32'h0);
    chk("f2_rd_from_cr", 32'(rd_bit), 32'h1);

    // Field 5: re-issue while pending, accepted only with same-cycle wb1.
    issue(3'd5);
    iss_valid = 1'b1; iss_field = 3'd5;
    #1;
    chk("f5_iss_blocked", 32'(iss_ready), 32'h0);
    wb1_valid = 1'b1; wb1_field = 3'd5; wb1_data = 4'b1000;
    #1;
    chk("f5_iss_ready_wb", 32'(iss_ready), 32'h1);
    tick();
    iss_valid = 1'b0; wb1_valid = 1'b0;
    rd_bc = 5'd20;
    #1;
    chk("f5_cr", cr, 32'h0040_0800);
    chk("f5_still_pend", 32'(rd_ready), 32'h0);
    chk("f5_busy", 32'(busy), 32'h1);
    wb0_valid = 1'b1; wb0_field = 3'd5; wb0_data = 4'h0;
    tick();
    wb0_valid = 1'b0;
    chk("f5_cr_clr", cr, 32'h0040_0000);
    chk("f5_busy_clr", 32'(busy), 32'h0);

    // mtcrf mask 0x81 held by pending field 7 until wb0 retires it.
    issue(3'd7);
    mt_valid = 1'b1; mt_mask = 8'h81; mt_data = 32'hA000_0005;
    #1;
    chk("mt_blocked", 32'(mt_ready), 32'h0);
    tick();
    chk("mt_blocked_cr", cr, 32'h0040_0000);
    wb0_valid = 1'b1; wb0_field = 3'd7; wb0_data = 4'hF;
    #1;
    chk("mt_ready_wb", 32'(mt_ready), 32'h1);
    tick();
    mt_valid = 1'b0; wb0_valid = 1'b0;
    chk("mt_cr", cr, 32'hA040_0005);
    chk("mt_busy", 32'(busy), 32'h0);
    chk("mt_err", 32'(err), 32'h0);

    // mtcrf plus same-cycle reservation of a masked field.
    mt_valid = 1'b1; mt_mask = 8'h80; mt_data = 32'hF000_0000;
    iss_valid = 1'b1; iss_field = 3'd0;
    #1;
    chk("mt_iss_mt_ready", 32'(mt_ready), 32'h1);
    tick();
    mt_valid = 1'b0; iss_valid = 1'b0;
    chk("mt_iss_cr", cr, 32'hF040_0005);
    chk("mt_iss_busy", 32'(busy), 32'h1);

    // Both writeback ports hit pending field 0: wb0 wins, err sticks.
    wb0_valid = 1'b1; wb0_field = 3'd0; wb0_data = 4'h2;
    wb1_valid = 1'b1; wb1_field = 3'd0; wb1_data = 4'h4;
    rd_bc = 5'd2;
    #1;
    chk("dual_rd_bit_wb0", 32'(rd_bit), 32'h1);
    tick();
    wb0_valid = 1'b0; wb1_valid = 1'b0;
    chk("dual_cr", cr, 32'h2040_0005);
    chk("dual_err", 32'(err), 32'h1);
    chk("dual_busy", 32'(busy), 32'h0);
    tick();
    tick();
    chk("err_sticky", 32'(err), 32'h1);

    // Writeback to a non-pending field is ignored and flags err.
    do_reset();
    chk("rst2_err", 32'(err), 32'h0);
    wb0_valid = 1'b1; wb0_field = 3'd3; wb0_data = 4'hF;
    rd_bc = 5'd12;
    #1;
    chk("np_rd_no_bypass", 32'(rd_bit), 32'h0);
    tick();
    wb0_valid = 1'b0;
    chk("np_cr", cr, 32'h0);
    chk("np_err", 32'(err), 32'h1);

    // Reset with every field pending drops all reservations.
    for (int f = 0; f < 8; f++) issue(3'(f));
    chk("full_busy", 32'(busy), 32'h1);
    rd_bc = 5'd31;
    #1;
    chk("full_rd_blocked", 32'(rd_ready), 32'h0);
    chk("full_iss_blocked", 32'(iss_ready), 32'h0);
    wb1_valid = 1'b1; wb1_field = 3'd1; wb1_data = 4'h7;
    tick();
    wb1_valid = 1'b0;
    chk("full_wb1_cr", cr, 32'h0700_0000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("frst_cr", cr, 32'h0);
    chk("frst_busy", 32'(busy), 32'h0);
    chk("frst_err", 32'(err), 32'h0);
    chk("frst_rd_ready", 32'(rd_ready), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
